// File: rtl/flash_read_arbiter_pkg.sv
// Shared definitions for the two-requester flash read arbiter.
//   state_e     : arbiter FSM states (legacy encoding kept explicit)
//   FLASH_BURST : fixed Avalon burstcount (single-word reads)
//   FLASH_BE    : fixed Avalon byteenable (full 32-bit word)
//   cnt_width() : watchdog counter width able to hold TIMEOUT
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [6:0] FLASH_BURST = 7'd1;
  localparam logic [3:0] FLASH_BE    = 4'hF;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/flash_read_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
//   req_i  : request bits of requesters 0 and 1
//   last_i : index of the requester served most recently
//   gnt_o  : one-hot pick, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    // On a tie the requester that was not served last wins.
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read port between two requesters.
// Round-robin arbitration, one outstanding single-word read, watchdog abort.
//   clk, rst                : clock, synchronous active-high reset
//   req, addr0, addr1       : requester side (level request, word address)
//   gnt, rsp_valid, rdata,
//   rsp_err, busy           : owner, response pulse, data, timeout flag, activity
//   flash_mem_*             : Avalon-MM master read port (write side tied off)
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        gnt,
  output logic [1:0]        rsp_valid,
  output logic [31:0]       rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              flash_mem_read,
  output logic              flash_mem_write,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [6:0]        flash_mem_burstcount,
  output logic [3:0]        flash_mem_byteenable,
  output logic [31:0]       flash_mem_writedata,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              read_q, read_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        pick;
  logic              expire;
  logic              done_ok;
  logic              done_err;

  rr_arb2 u_rr_arb2 (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Counter holds the number of cycles already spent in ISSUE/WAIT, so the
  // edge that would make it reach TIMEOUT is the abort edge.
  assign expire = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    rsp_err_d   = 1'b0;
    read_d      = read_q;
    last_d      = last_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    done_ok     = 1'b0;
    done_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          gnt_d   = pick;
          addr_d  = pick[1] ? addr1 : addr0;
          read_d  = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (expire) begin
          done_err = 1'b1;
        end else if (!flash_mem_waitrequest) begin
          read_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Data arriving on the expiry cycle still counts as a normal response.
        if (flash_mem_readdatavalid) begin
          done_ok = 1'b1;
        end else if (expire) begin
          done_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_ok || done_err) begin
      rdata_d     = done_ok ? flash_mem_readdata : '0;
      rsp_err_d   = done_err;
      rsp_valid_d = gnt_q;
      last_d      = gnt_q[1];
      gnt_d       = '0;
      read_d      = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      read_q      <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
      read_q      <= read_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt                  = gnt_q;
  assign rsp_valid            = rsp_valid_q;
  assign rdata                = rdata_q;
  assign rsp_err              = rsp_err_q;
  assign busy                 = (state_q != IDLE);
  assign flash_mem_read       = read_q;
  assign flash_mem_write      = 1'b0;
  assign flash_mem_address    = addr_q;
  assign flash_mem_burstcount = FLASH_BURST;
  assign flash_mem_byteenable = FLASH_BE;
  assign flash_mem_writedata  = '0;

endmodule

// File: tb/tb_flash_read_arbiter.sv
module tb_flash_read_arbiter;

  localparam int TIMEOUT = 64;
  localparam int ADDR_W  = 23;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_lvl = 2'b00;
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [1:0]        gnt;
  logic [1:0]        rsp_valid;
  logic [31:0]       rdata;
  logic              rsp_err;
  logic              busy;
  logic              flash_mem_read;
  logic              flash_mem_write;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [6:0]        flash_mem_burstcount;
  logic [3:0]        flash_mem_byteenable;
  logic [31:0]       flash_mem_writedata;
  logic              waitreq = 1'b0;
  logic [31:0]       rdat = '0;
  logic              rdv = 1'b0;

  // Requesters drop their level request in the cycle their response shows up.
  assign req = req_lvl & ~rsp_valid;

  always #5 clk = ~clk;

  flash_read_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .req                     (req),
    .addr0                   (addr0),
    .addr1                   (addr1),
    .gnt                     (gnt),
    .rsp_valid               (rsp_valid),
    .rdata                   (rdata),
    .rsp_err                 (rsp_err),
    .busy                    (busy),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_write         (flash_mem_write),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_burstcount    (flash_mem_burstcount),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_writedata     (flash_mem_writedata),
    .flash_mem_waitrequest   (waitreq),
    .flash_mem_readdata      (rdat),
    .flash_mem_readdatavalid (rdv)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash contents as 16-bit halfwords; word A = {hw[2A+1], hw[2A]}.
  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    logic [15:0] lo;
    logic [15:0] hi;
    if (a == ADDR_W'(0)) begin
      lo = 16'hE364; hi = 16'hC6C8;
    end else if (a == ADDR_W'(127)) begin
      lo = 16'h18D8; hi = 16'h1919;
    end else begin
      lo = a[15:0] ^ 16'h5A5A; hi = ~a[15:0];
    end
    return {hi, lo};
  endfunction

  // ---------------- flash slave model ----------------
  int                cfg_stall  = 0;
  int                cfg_lat    = 1;
  bit                cfg_noresp = 0;
  int                stall_left = 0;
  int                pend       = 0;
  bit                acc_seen   = 0;
  int                accepts    = 0;
  int                read_cycles = 0;
  logic [ADDR_W-1:0] acc_addr   = '0;
  logic [ADDR_W-1:0] pend_addr  = '0;

  always @(negedge clk) begin
    acc_seen = (flash_mem_read === 1'b1) && !waitreq;
    if (acc_seen) begin
      accepts++;
      acc_addr = flash_mem_address;
    end
    if (flash_mem_read === 1'b1) read_cycles++;
  end

  always begin
    @(posedge clk);
    #2;
    rdv  = 1'b0;
    rdat = 32'hDEAD0000 | 32'(cyc[15:0]);
    if (rst) begin
      pend = 0;
    end else begin
      if (acc_seen && !cfg_noresp) begin
        pend      = cfg_lat;
        pend_addr = acc_addr;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rdv  = 1'b1;
          rdat = word_at(pend_addr);
        end
      end
    end
    if (flash_mem_read !== 1'b1) begin
      waitreq    = 1'b0;
      stall_left = cfg_stall;
    end else if (stall_left > 0) begin
      waitreq = 1'b1;
      stall_left--;
    end else begin
      waitreq = 1'b0;
    end
  end

  // ---------------- transaction-level reference model ----------------
  int                m_owner = -1;
  int                m_age   = 0;
  bit                m_acc   = 0;
  bit                m_last  = 1;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [31:0]       m_rdata = '0;
  logic [1:0]        m_rv    = '0;
  logic              m_err   = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rdata", rdata, m_rdata);
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("read", 32'(flash_mem_read), 32'((m_owner >= 0) && !m_acc));
      chk("address", 32'(flash_mem_address), 32'(m_addr));
      chk("tieoffs", {flash_mem_write, flash_mem_burstcount, flash_mem_byteenable,
                      20'(flash_mem_writedata)}, {1'b0, 7'd1, 4'hF, 20'd0});
    end
    if (rst) begin
      m_owner = -1; m_acc = 0; m_last = 1; m_addr = '0;
      m_rdata = '0; m_rv = '0; m_err = 1'b0;
    end else begin
      m_rv  = '0;
      m_err = 1'b0;
      if (m_owner < 0) begin
        if (req != 2'b00) begin
          if (req == 2'b11) m_owner = m_last ? 0 : 1;
          else              m_owner = req[1] ? 1 : 0;
          m_addr = (m_owner == 1) ? addr1 : addr0;
          m_age  = 0;
          m_acc  = 0;
        end
      end else begin
        m_age++;
        if ((m_acc && rdv) || m_age == TIMEOUT) begin
          m_err   = !(m_acc && rdv);
          m_rdata = m_err ? 32'd0 : rdat;
          m_rv    = 2'(1 << m_owner);
          m_last  = (m_owner == 1);
          m_owner = -1;
        end else if (!m_acc && !waitreq) begin
          m_acc = 1;
        end
      end
    end
  end

  // ---------------- response recorder ----------------
  logic [1:0]  r_rv[$];
  logic [31:0] r_data[$];
  logic        r_err[$];
  int          r_cyc[$];

  always @(negedge clk) begin
    if (chk_en && rsp_valid !== 2'b00) begin
      r_rv.push_back(rsp_valid);
      r_data.push_back(rdata);
      r_err.push_back(rsp_err);
      r_cyc.push_back(cyc);
    end
  end

  task automatic clear_rsp();
    r_rv.delete(); r_data.delete(); r_err.delete(); r_cyc.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int i = 0;
    while (r_rv.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk("rsp_count", 32'(r_rv.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    @(negedge clk); #1;
    while (busy !== 1'b0 && i < budget) begin @(negedge clk); #1; i++; end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int c0;

  initial begin
    // Reset state
    step(2);
    chk_en = 1;
    @(negedge clk); #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_read", 32'(flash_mem_read), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_address", 32'(flash_mem_address), 32'd0);
    step(1);
    rst = 1'b0;
    step(2);

    // Single read, requester 0, addr 0
    addr0 = '0;
    req_lvl = 2'b01;
    c0 = cyc;
    wait_rsp(1, 20);
    if (r_rv.size() >= 1) begin
      chk("single_rv", 32'(r_rv[0]), 32'h1);
      chk("single_rdata", r_data[0], 32'hC6C8E364);
      chk("single_err", 32'(r_err[0]), 32'd0);
      chk("single_latency", 32'(r_cyc[0] - c0), 32'd3);
    end
    step(1);
    req_lvl = 2'b00;
    wait_idle(20);
    clear_rsp();

    // Waitrequest stall of 3 cycles, requester 1, addr 127
    step(1);
    cfg_stall = 3; accepts = 0; read_cycles = 0;
    addr1 = ADDR_W'(127);
    req_lvl = 2'b10;
    wait_rsp(1, 30);
    if (r_rv.size() >= 1) begin
      chk("stall_rv", 32'(r_rv[0]), 32'h2);
      chk("stall_rdata", r_data[0], 32'h191918D8);
    end
    chk("stall_accepts", 32'(accepts), 32'd1);
    chk("stall_read_cycles", 32'(read_cycles), 32'd4);
    step(1);
    req_lvl = 2'b00;
    cfg_stall = 0;
    wait_idle(20);
    clear_rsp();

    // Contention: both held, grants alternate starting with 0
    step(1);
    addr0 = '0;
    addr1 = ADDR_W'(127);
    req_lvl = 2'b11;
    wait_rsp(4, 60);
    for (int i = 0; i < 4 && i < r_rv.size(); i++) begin
      chk("rr_owner", 32'(r_rv[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_rdata", r_data[i], (i % 2 == 0) ? 32'hC6C8E364 : 32'h191918D8);
    end
    step(1);
    req_lvl = 2'b00;
    wait_idle(20);
    clear_rsp();

    // Timeout: slave never returns data
    step(1);
    cfg_noresp = 1;
    req_lvl = 2'b01;
    c0 = cyc;
    wait_rsp(1, 100);
    if (r_rv.size() >= 1) begin
      chk("tmo_rv", 32'(r_rv[0]), 32'h1);
      chk("tmo_err", 32'(r_err[0]), 32'd1);
      chk("tmo_rdata", r_data[0], 32'd0);
      chk("tmo_delay", 32'(r_cyc[0] - (c0 + 1)), 32'd64);
    end
    step(1);
    req_lvl = 2'b00;
    cfg_noresp = 0;
    @(negedge clk); #1;
    chk("tmo_busy_after", 32'(busy), 32'd0);
    clear_rsp();

    // Reset while in WAIT; afterwards a tie goes to requester 0
    step(1);
    cfg_lat = 10;
    req_lvl = 2'b01;
    step(3);
    rst = 1'b1;
    req_lvl = 2'b11;
    step(1);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rmid_gnt", 32'(gnt), 32'd0);
    chk("rmid_read", 32'(flash_mem_read), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
    step(1);
    @(negedge clk); #1;
    chk("rmid_tie_gnt", 32'(gnt), 32'h1);
    wait_rsp(2, 60);
    step(1);
    req_lvl = 2'b00;
    wait_idle(40);
    clear_rsp();

    // Requester 0 abandons during WAIT while requester 1 is pending
    step(1);
    cfg_lat = 5;
    req_lvl = 2'b01;
    step(3);
    req_lvl = 2'b10;
    wait_rsp(1, 30);
    if (r_rv.size() >= 1) chk("abandon_rv", 32'(r_rv[0]), 32'h1);
    step(1);
    @(negedge clk); #1;
    chk("abandon_next_gnt", 32'(gnt), 32'h2);
    wait_rsp(2, 30);
    step(1);
    req_lvl = 2'b00;
    wait_idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
